// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, three-state
// accept/execute/respond sequencing and saturating per-requester completion counters.
module alu_share_arbiter #(
    parameter int CNT_W     = 16,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid_0,
    input  logic [5:0]       req_func_0,
    input  logic [31:0]      req_a_0,
    input  logic [31:0]      req_b_0,
    output logic             req_ready_0,
    input  logic             req_valid_1,
    input  logic [5:0]       req_func_1,
    input  logic [31:0]      req_a_1,
    input  logic [31:0]      req_b_1,
    output logic             req_ready_1,
    output logic             rsp_valid_0,
    output logic [31:0]      rsp_data_0,
    input  logic             rsp_ready_0,
    output logic             rsp_valid_1,
    output logic [31:0]      rsp_data_1,
    input  logic             rsp_ready_1,
    output logic             busy,
    output logic [CNT_W-1:0] op_count_0,
    output logic [CNT_W-1:0] op_count_1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [5:0]       func_q, func_d;
    logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [31:0]      alu_res;
    logic             idle, grant, accept, done;

    assign idle   = (state_q == IDLE);
    // Contention goes to the pointer; otherwise whichever side is valid.
    assign grant  = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
    assign accept = idle && (req_valid_0 || req_valid_1);
    assign done   = (state_q == RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);

    assign req_ready_0 = reset_n && idle && req_valid_0 && !grant;
    assign req_ready_1 = reset_n && idle && req_valid_1 && grant;
    assign rsp_valid_0 = (state_q == RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == RESP) && owner_q;
    assign rsp_data_0  = rsp_valid_0 ? res_q : 32'd0;
    assign rsp_data_1  = rsp_valid_1 ? res_q : 32'd0;
    assign busy        = !idle;
    assign op_count_0  = cnt0_q;
    assign op_count_1  = cnt1_q;

    // Shift amounts use the full 32-bit operand, so B >= 32 yields zero.
    always_comb begin
        alu_res = 32'd0;
        case (func_q)
            6'b100000, 6'b100001: alu_res = a_q + b_q;
            6'b100010:            alu_res = a_q - b_q;
            6'b100100:            alu_res = a_q & b_q;
            6'b100101:            alu_res = a_q | b_q;
            6'b000000:            alu_res = a_q << b_q;
            6'b000010, 6'b000011: alu_res = a_q >> b_q;
            6'b101011:            alu_res = {31'd0, a_q < b_q};
            default:              alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = EXEC;
                owner_d = grant;
                func_d  = grant ? req_func_1 : req_func_0;
                a_d     = grant ? req_a_1 : req_a_0;
                b_d     = grant ? req_b_1 : req_b_0;
            end
            EXEC: begin
                state_d = RESP;
                res_d   = alu_res;
            end
            RESP: if (done) begin
                state_d = IDLE;
                prio_d  = !owner_q;
                if (!owner_q && !(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
                if (owner_q && !(&cnt1_q))  cnt1_d = cnt1_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prio_q  <= PRIO_INIT;
            owner_q <= 1'b0;
            func_q  <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: drivers queue expected results, a negedge
// monitor tracks grant/latency/counter expectations and pops results as they appear.
module tb_alu_share_arbiter;

    localparam int CNT_W = 2;
    localparam int PRIO_INIT = 0;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       v, rdy, rr, rv;
    logic [1:0][5:0]  fn;
    logic [1:0][31:0] ra, rb, rd;
    logic [1:0][CNT_W-1:0] oc;
    logic             busy;

    int nchk = 0, nerr = 0, ndone = 0;
    logic [31:0] q [2][$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.CNT_W(CNT_W), .PRIO_INIT(PRIO_INIT)) dut (
        .clk(clk), .reset_n(rst_n),
        .req_valid_0(v[0]), .req_func_0(fn[0]), .req_a_0(ra[0]), .req_b_0(rb[0]), .req_ready_0(rr[0]),
        .req_valid_1(v[1]), .req_func_1(fn[1]), .req_a_1(ra[1]), .req_b_1(rb[1]), .req_ready_1(rr[1]),
        .rsp_valid_0(rv[0]), .rsp_data_0(rd[0]), .rsp_ready_0(rdy[0]),
        .rsp_valid_1(rv[1]), .rsp_data_1(rd[1]), .rsp_ready_1(rdy[1]),
        .busy(busy), .op_count_0(oc[0]), .op_count_1(oc[1])
    );

    function automatic logic [31:0] ref_alu(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        case (f)
            6'h20, 6'h21: return a + b;
            6'h22:        return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h00:        return (b >= 32) ? 32'd0 : (a << b[4:0]);
            6'h02, 6'h03: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
            6'h2B:        return (a < b) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drv(int x, logic [5:0] f, logic [31:0] a, logic [31:0] b);
        v[x] = 1'b1; fn[x] = f; ra[x] = a; rb[x] = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rr[x]) begin
                q[x].push_back(ref_alu(f, a, b));
                @(posedge clk); #1;
                v[x] = 1'b0;
                return;
            end
        end
        nchk++; nerr++;
        $display("FAIL drv_timeout: requester %0d never got req_ready", x);
        v[x] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        nchk++; nerr++;
        $display("FAIL idle_timeout: busy still 1");
    endtask

    // Reference model: one operation in flight; response due two samples after acceptance.
    int cyc = 0, own_m = 0, acc_c = 0, prio_m = PRIO_INIT;
    bit out_m = 0, seen = 0;
    logic [31:0] hold;
    logic [CNT_W-1:0] cnt_m [2];
    logic e_rr0, e_rr1, e_rv;
    initial begin cnt_m[0] = '0; cnt_m[1] = '0; end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            out_m = 0; seen = 0; prio_m = PRIO_INIT;
            cnt_m[0] = '0; cnt_m[1] = '0;
            q[0].delete(); q[1].delete();
            chk("rst_rr", {30'd0, rr}, 32'd0);
            chk("rst_rv", {30'd0, rv}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rd0", rd[0], 32'd0);
            chk("rst_rd1", rd[1], 32'd0);
            chk("rst_cnt", {{(32-2*CNT_W){1'b0}}, oc}, 32'd0);
        end else begin
            e_rr0 = !out_m && v[0] && (!v[1] || prio_m == 0);
            e_rr1 = !out_m && v[1] && (!v[0] || prio_m == 1);
            chk("req_ready_0", {31'd0, rr[0]}, {31'd0, e_rr0});
            chk("req_ready_1", {31'd0, rr[1]}, {31'd0, e_rr1});
            chk("busy", {31'd0, busy}, {31'd0, out_m});
            for (int x = 0; x < 2; x++) begin
                chk($sformatf("op_count_%0d", x), {{(32-CNT_W){1'b0}}, oc[x]}, {{(32-CNT_W){1'b0}}, cnt_m[x]});
                e_rv = out_m && own_m == x && cyc >= acc_c + 2;
                chk($sformatf("rsp_valid_%0d", x), {31'd0, rv[x]}, {31'd0, e_rv});
                if (e_rv && rv[x]) begin
                    if (!seen) begin
                        if (q[x].size() == 0) begin
                            nchk++; nerr++;
                            $display("FAIL sb_empty: response on %0d with nothing expected", x);
                            hold = rd[x];
                        end else begin
                            hold = q[x].pop_front();
                        end
                        seen = 1;
                        chk($sformatf("rsp_data_%0d", x), rd[x], hold);
                    end else begin
                        chk($sformatf("rsp_hold_%0d", x), rd[x], hold);
                    end
                end else if (!(out_m && own_m == x)) begin
                    chk($sformatf("rsp_data_idle_%0d", x), rd[x], 32'd0);
                end
            end
            if (out_m && cyc >= acc_c + 2 && rdy[own_m]) begin
                if (cnt_m[own_m] != CMAX[CNT_W-1:0]) cnt_m[own_m] = cnt_m[own_m] + 1'b1;
                prio_m = 1 - own_m;
                out_m = 0; seen = 0;
            end else if (e_rr0 || e_rr1) begin
                out_m = 1; own_m = e_rr1 ? 1 : 0; acc_c = cyc;
            end
        end
    end

    task automatic rnd_req(int x, int n);
        logic [5:0] codes [11];
        logic [31:0] b;
        codes = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h2B, 6'h3F, 6'h01};
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drv(x, codes[$urandom_range(0, 10)], $urandom, b);
        end
        ndone++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ef [5];
        logic [31:0] ea [5], eb [5];
        int bc;
        rst_n = 1'b0; v = '0; rdy = 2'b11; fn = '0; ra = '0; rb = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // single add that wraps; busy covers EXEC and RESP
        drv(0, 6'b100000, 32'hFFFFFFFF, 32'd2);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) bc++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", bc, 2);
        chk("single_cnt0", {{(32-CNT_W){1'b0}}, oc[0]}, 32'd1);

        // contention: grants alternate under continuous valid
        fork
            begin drv(0, 6'b100010, 32'd5, 32'd7); drv(0, 6'b100010, 32'd5, 32'd7); end
            begin drv(1, 6'b101011, 32'd3, 32'hFFFFFFFF); drv(1, 6'b101011, 32'd3, 32'hFFFFFFFF); end
        join
        wait_idle();

        // backpressure on requester 1 while requester 0 waits
        rdy[1] = 1'b0;
        fork
            drv(1, 6'b000011, 32'h80000000, 32'd4);
            begin
                bc = 0;
                while (!rv[1] && bc < 20) begin @(posedge clk); #1; bc++; end
                chk("bp_rv1", {31'd0, rv[1]}, 32'd1);
                fork
                    drv(0, 6'b100101, 32'h12340000, 32'h00005678);
                    begin repeat (5) @(posedge clk); #1 rdy[1] = 1'b1; end
                join
            end
        join
        wait_idle();

        // opcode edges
        ef = '{6'b000000, 6'b000010, 6'b100100, 6'b100101, 6'b111111};
        ea = '{32'd1, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hDEADBEEF};
        eb = '{32'd32, 32'd31, 32'h0FF00FF0, 32'h0FF00FF0, 32'h12345678};
        for (int i = 0; i < 5; i++) begin
            drv(i % 2, ef[i], ea[i], eb[i]);
            wait_idle();
        end

        // reset during EXEC drops the op
        drv(0, 6'b100000, 32'd10, 32'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rv", {30'd0, rv}, 32'd0);
        chk("mid_rst_rd0", rd[0], 32'd0);
        chk("mid_rst_rr", {30'd0, rr}, 32'd0);
        chk("mid_rst_cnt", {{(32-2*CNT_W){1'b0}}, oc}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_rv", {30'd0, rv}, 32'd0);
        chk("post_rst_cnt", {{(32-2*CNT_W){1'b0}}, oc}, 32'd0);

        // counter saturation on requester 1
        for (int i = 0; i < 5; i++) begin
            drv(1, 6'b100000, 32'(i), 32'd1);
            wait_idle();
            chk("sat_cnt1", {{(32-CNT_W){1'b0}}, oc[1]}, (i + 1 > CMAX) ? CMAX : i + 1);
            chk("sat_cnt0", {{(32-CNT_W){1'b0}}, oc[0]}, 32'd0);
        end

        // randomized traffic with random response backpressure
        ndone = 0;
        fork
            rnd_req(0, 15);
            rnd_req(1, 15);
            begin
                while (ndone < 2) begin
                    @(posedge clk); #1;
                    rdy[0] = ($urandom_range(0, 3) != 0);
                    rdy[1] = ($urandom_range(0, 3) != 0);
                end
                rdy = 2'b11;
            end
        join
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", q[0].size() + q[1].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
